// File: rtl/sdr_block_unpacker.sv
// sdr_block_unpacker: latches one SDRAM read block, streams it as words.
// Optional build macro SDR_UNPACK_BSWAP_EN byte-reverses each output word.
module sdr_block_unpacker #(
  parameter int BLOCK_W = 2048,
  parameter int WORD_W  = 32,
  localparam int NWORDS = BLOCK_W / WORD_W,
  localparam int IDX_W  = $clog2(NWORDS)
) (
  input  logic               sdr_clk,
  input  logic               sdr_reset,
  input  logic [BLOCK_W-1:0] blk_data,
  input  logic               blk_valid,
  input  logic [29:0]        blk_nwords,
  output logic               blk_ready,
  output logic [WORD_W-1:0]  word_data,
  output logic [IDX_W-1:0]   word_idx,
  output logic               word_valid,
  output logic               word_last,
  input  logic               word_ready,
  output logic               blk_done,
  output logic               blk_drop
);

  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [BLOCK_W-1:0] shadow_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_d;
  logic               done_q;
  logic               done_d;
  logic               drop_q;
  logic               drop_d;
  logic               load;
  logic [CNT_W-1:0]   clamp;
  logic [WORD_W-1:0]  slice;
  logic               xfer;

  // Oversized blocks are silently truncated to one full block.
  assign clamp = (blk_nwords > 30'(NWORDS)) ?
                 CNT_W'(NWORDS) : blk_nwords[CNT_W-1:0];

  assign slice      = shadow_q[idx_q*WORD_W +: WORD_W];
  assign blk_ready  = (state_q == IDLE);
  assign word_valid = (state_q == STREAM);
  assign word_idx   = idx_q;
  assign word_last  = word_valid &&
                      ({1'b0, idx_q} == cnt_q - CNT_W'(1));
  assign xfer       = word_valid && word_ready;
  assign blk_done   = done_q;
  assign blk_drop   = drop_q;

`ifdef SDR_UNPACK_BSWAP_EN
  for (genvar b = 0; b < WORD_W / 8; b++) begin : g_bswap
    assign word_data[b*8 +: 8] = slice[WORD_W-8-b*8 +: 8];
  end
`else
  assign word_data = slice;
`endif

  // State register; reset drops any partial block at once.
  always_ff @(posedge sdr_clk or posedge sdr_reset) begin
    if (sdr_reset) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Block shadow, word counter/index and the one-cycle status pulses.
  always_ff @(posedge sdr_clk or posedge sdr_reset) begin
    if (sdr_reset) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      if (load) shadow_q <= blk_data;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      done_q <= done_d;
      drop_q <= drop_d;
    end
  end

  // Next state: accept only when idle, advance on each transfer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (blk_valid) begin
          load  = 1'b1;
          cnt_d = clamp;
          idx_d = '0;
          if (clamp != '0) state_d = STREAM;
          else             done_d  = 1'b1;
        end
      end
      STREAM: begin
        drop_d = blk_valid;
        if (xfer) begin
          if (word_last) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        drop_d  = blk_valid;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sdr_block_unpacker.sv
// tb_sdr_block_unpacker: scoreboard bench for the block unpacker.
// Build with SDR_UNPACK_BSWAP_EN to check the byte-swapped variant.
module tb_sdr_block_unpacker;

  logic          sdr_clk;
  logic          sdr_reset;
  logic [2047:0] blk_data;
  logic          blk_valid;
  logic [29:0]   blk_nwords;
  logic          blk_ready;
  logic [31:0]   word_data;
  logic [5:0]    word_idx;
  logic          word_valid;
  logic          word_last;
  logic          word_ready;
  logic          blk_done;
  logic          blk_drop;

  typedef struct {
    logic [31:0] d;
    logic [5:0]  i;
    logic        l;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  sdr_block_unpacker dut (
    .sdr_clk    (sdr_clk),
    .sdr_reset  (sdr_reset),
    .blk_data   (blk_data),
    .blk_valid  (blk_valid),
    .blk_nwords (blk_nwords),
    .blk_ready  (blk_ready),
    .word_data  (word_data),
    .word_idx   (word_idx),
    .word_valid (word_valid),
    .word_last  (word_last),
    .word_ready (word_ready),
    .blk_done   (blk_done),
    .blk_drop   (blk_drop)
  );

  initial begin
    sdr_clk = 1'b0;
    forever #5 sdr_clk = ~sdr_clk;
  end

  function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef SDR_UNPACK_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic send_block(input logic [31:0] base,
                            input logic [29:0] n);
    int m;
    exp_t e;
    m = (n > 30'd64) ? 64 : int'(n);
    for (int k = 0; k < 64; k++)
      blk_data[k*32 +: 32] = base + 32'(k);
    for (int k = 0; k < m; k++) begin
      e.d = sw(base + 32'(k));
      e.i = 6'(k);
      e.l = (k == m - 1);
      sb.push_back(e);
    end
    blk_nwords = n;
    blk_valid  = 1'b1;
    @(negedge sdr_clk);
    blk_valid  = 1'b0;
  endtask

  task automatic test_reset;
    blk_data   = '0;
    blk_valid  = 1'b0;
    blk_nwords = '0;
    word_ready = 1'b0;
    sdr_reset  = 1'b1;
    @(negedge sdr_clk);
    @(negedge sdr_clk);
    checks++;
    if ({blk_ready, word_valid, word_last, blk_done, blk_drop}
        !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=10000",
               {blk_ready, word_valid, word_last, blk_done, blk_drop});
    end
    checks++;
    if (word_data !== 32'h0 || word_idx !== 6'd0) begin
      failures++;
      $display("FAIL reset_data got=%h/%0d want=0/0",
               word_data, word_idx);
    end
    sdr_reset = 1'b0;
    @(negedge sdr_clk);
    checks++;
    if (blk_ready !== 1'b1 || word_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got rdy=%b vld=%b want 1/0",
               blk_ready, word_valid);
    end
  endtask

  task automatic test_stream;
    int cyc;
    exp_t e;
    send_block(32'hA000_0000, 30'd15);
    word_ready = 1'b1;
    cyc = 0;
    while (sb.size() > 0 && cyc < 100) begin
      if (word_valid && word_ready) begin
        e = sb.pop_front();
        checks++;
        if ({word_data, word_idx, word_last} !== {e.d, e.i, e.l}) begin
          failures++;
          $display("FAIL stream_word got=%h/%0d/%b want=%h/%0d/%b",
                   word_data, word_idx, word_last, e.d, e.i, e.l);
        end
      end
      cyc++;
      @(negedge sdr_clk);
    end
    checks++;
    if (sb.size() != 0 || cyc != 15) begin
      failures++;
      $display("FAIL stream_cycles got=%0d left=%0d want=15 left=0",
               cyc, sb.size());
    end
    checks++;
    if (blk_done !== 1'b1 || word_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_done got done=%b vld=%b want 1/0",
               blk_done, word_valid);
    end
    @(negedge sdr_clk);
    checks++;
    if (blk_done !== 1'b0 || blk_ready !== 1'b1) begin
      failures++;
      $display("FAIL stream_idle got done=%b rdy=%b want 0/1",
               blk_done, blk_ready);
    end
  endtask

  task automatic test_stall;
    int cyc;
    int xf;
    logic stalled;
    logic [31:0] sd;
    logic [5:0] si;
    exp_t e;
    send_block(32'hB000_0000, 30'd15);
    cyc = 0;
    xf = 0;
    stalled = 1'b0;
    sd = '0;
    si = '0;
    while (sb.size() > 0 && cyc < 200) begin
      word_ready = (cyc % 3 == 0);
      if (stalled) begin
        checks++;
        if (word_data !== sd || word_idx !== si || !word_valid) begin
          failures++;
          $display("FAIL stall_hold got=%h/%0d/%b want=%h/%0d/1",
                   word_data, word_idx, word_valid, sd, si);
        end
      end
      stalled = word_valid && !word_ready;
      sd = word_data;
      si = word_idx;
      if (word_valid && word_ready) begin
        e = sb.pop_front();
        xf++;
        checks++;
        if ({word_data, word_idx, word_last} !== {e.d, e.i, e.l}) begin
          failures++;
          $display("FAIL stall_word got=%h/%0d/%b want=%h/%0d/%b",
                   word_data, word_idx, word_last, e.d, e.i, e.l);
        end
      end
      cyc++;
      @(negedge sdr_clk);
    end
    word_ready = 1'b0;
    checks++;
    if (xf != 15 || sb.size() != 0 || blk_done !== 1'b1) begin
      failures++;
      $display("FAIL stall_count got=%0d done=%b want=15 done=1",
               xf, blk_done);
    end
    @(negedge sdr_clk);
  endtask

  task automatic test_zero_and_clamp;
    int cyc;
    exp_t e;
    send_block(32'hC000_0000, 30'd0);
    checks++;
    if ({blk_done, word_valid, blk_ready} !== 3'b101) begin
      failures++;
      $display("FAIL zero_done got=%b want=101",
               {blk_done, word_valid, blk_ready});
    end
    @(negedge sdr_clk);
    checks++;
    if ({blk_done, word_valid, blk_ready} !== 3'b001) begin
      failures++;
      $display("FAIL zero_after got=%b want=001",
               {blk_done, word_valid, blk_ready});
    end
    send_block(32'hC100_0000, 30'd100);
    word_ready = 1'b1;
    cyc = 0;
    while (sb.size() > 0 && cyc < 200) begin
      if (word_valid && word_ready) begin
        e = sb.pop_front();
        checks++;
        if ({word_data, word_idx, word_last} !== {e.d, e.i, e.l}) begin
          failures++;
          $display("FAIL clamp_word got=%h/%0d/%b want=%h/%0d/%b",
                   word_data, word_idx, word_last, e.d, e.i, e.l);
        end
      end
      cyc++;
      @(negedge sdr_clk);
    end
    word_ready = 1'b0;
    checks++;
    if (cyc != 64 || sb.size() != 0 || blk_done !== 1'b1) begin
      failures++;
      $display("FAIL clamp_count got=%0d done=%b want=64 done=1",
               cyc, blk_done);
    end
    @(negedge sdr_clk);
  endtask

  task automatic test_drop;
    int cyc;
    logic seen;
    exp_t e;
    send_block(32'hD000_0000, 30'd15);
    for (int k = 0; k < 64; k++)
      blk_data[k*32 +: 32] = 32'hDEAD_0000 + 32'(k);
    blk_nwords = 30'd10;
    blk_valid  = 1'b1;
    @(negedge sdr_clk);
    blk_valid = 1'b0;
    checks++;
    if (blk_drop !== 1'b1 || word_idx !== 6'd0 ||
        word_data !== sw(32'hD000_0000) || blk_ready !== 1'b0) begin
      failures++;
      $display("FAIL drop_pulse got drop=%b %h/%0d want 1 %h/0",
               blk_drop, word_data, word_idx, sw(32'hD000_0000));
    end
    @(negedge sdr_clk);
    checks++;
    if (blk_drop !== 1'b0) begin
      failures++;
      $display("FAIL drop_once got=%b want=0", blk_drop);
    end
    word_ready = 1'b1;
    cyc = 0;
    while (sb.size() > 0 && cyc < 100) begin
      if (word_valid && word_ready) begin
        e = sb.pop_front();
        checks++;
        if ({word_data, word_idx, word_last} !== {e.d, e.i, e.l}) begin
          failures++;
          $display("FAIL drop_word got=%h/%0d/%b want=%h/%0d/%b",
                   word_data, word_idx, word_last, e.d, e.i, e.l);
        end
      end
      cyc++;
      @(negedge sdr_clk);
    end
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      seen |= word_valid;
      @(negedge sdr_clk);
    end
    word_ready = 1'b0;
    checks++;
    if (sb.size() != 0 || seen !== 1'b0) begin
      failures++;
      $display("FAIL drop_extra got left=%0d vld=%b want 0/0",
               sb.size(), seen);
    end
  endtask

  task automatic test_async_reset;
    int cyc;
    int xf;
    logic seen;
    exp_t e;
    send_block(32'hE000_0000, 30'd15);
    word_ready = 1'b1;
    cyc = 0;
    xf = 0;
    while (xf < 5 && cyc < 100) begin
      if (word_valid && word_ready) begin
        e = sb.pop_front();
        xf++;
        checks++;
        if ({word_data, word_idx, word_last} !== {e.d, e.i, e.l}) begin
          failures++;
          $display("FAIL rst_word got=%h/%0d/%b want=%h/%0d/%b",
                   word_data, word_idx, word_last, e.d, e.i, e.l);
        end
      end
      cyc++;
      @(negedge sdr_clk);
    end
    word_ready = 1'b0;
    #1 sdr_reset = 1'b1;
    #1;
    checks++;
    if (word_valid !== 1'b0 || blk_ready !== 1'b1 ||
        word_idx !== 6'd0) begin
      failures++;
      $display("FAIL rst_async got vld=%b rdy=%b idx=%0d want 0/1/0",
               word_valid, blk_ready, word_idx);
    end
    sb.delete();
    @(negedge sdr_clk);
    sdr_reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      seen |= blk_done | word_valid;
      @(negedge sdr_clk);
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_done got=%b want=0", seen);
    end
    send_block(32'hF000_0000, 30'd3);
    word_ready = 1'b1;
    cyc = 0;
    while (sb.size() > 0 && cyc < 100) begin
      if (word_valid && word_ready) begin
        e = sb.pop_front();
        checks++;
        if ({word_data, word_idx, word_last} !== {e.d, e.i, e.l}) begin
          failures++;
          $display("FAIL rst_next got=%h/%0d/%b want=%h/%0d/%b",
                   word_data, word_idx, word_last, e.d, e.i, e.l);
        end
      end
      cyc++;
      @(negedge sdr_clk);
    end
    word_ready = 1'b0;
    checks++;
    if (cyc != 3 || blk_done !== 1'b1) begin
      failures++;
      $display("FAIL rst_next_count got=%0d done=%b want=3 done=1",
               cyc, blk_done);
    end
    @(negedge sdr_clk);
  endtask

  task automatic test_bswap;
    logic [31:0] want;
    exp_t e;
`ifdef SDR_UNPACK_BSWAP_EN
    want = 32'h4433_2211;
`else
    want = 32'h1122_3344;
`endif
    send_block(32'h1122_3344, 30'd1);
    checks++;
    if (word_data !== want || word_valid !== 1'b1 ||
        word_last !== 1'b1) begin
      failures++;
      $display("FAIL bswap got=%h vld=%b last=%b want=%h 1 1",
               word_data, word_valid, word_last, want);
    end
    word_ready = 1'b1;
    if (sb.size() > 0) e = sb.pop_front();
    @(negedge sdr_clk);
    word_ready = 1'b0;
    checks++;
    if (blk_done !== 1'b1 || word_valid !== 1'b0) begin
      failures++;
      $display("FAIL bswap_done got done=%b vld=%b want 1/0",
               blk_done, word_valid);
    end
    @(negedge sdr_clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_stall();
    test_zero_and_clamp();
    test_drop();
    test_async_reset();
    test_bswap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
